mult8x8_seq: RTL and testbench
==============================

Name: mult8x8_seq

Overview:
Sequential 8x8 unsigned multiplier built around the existing combinational mult4x4 core. It consumes the 8-bit product of that core. Each operation takes four compute cycles:
- The block splits each 8-bit operand into 4-bit nibbles.
- It feeds one nibble pair per cycle into a single mult4x4 instance.
- It shifts each partial product into position and accumulates it into a 16-bit result.

This is the datapath plus control stage directly downstream of mult4x4.

Parameters:
- none: widths are fixed at 8x8 -> 16 by the mult4x4 core (4x4 -> 8).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request to multiply; sampled only in IDLE.
- dataa  input  8  multiplicand; captured on the accepting edge.
- datab  input  8  multiplier; captured on the accepting edge.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  single-cycle pulse; product is valid from this cycle onward.
- product  output  16  result register; holds its value until the next completion.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, step counter=0, internal operand regs=0, accumulator=0.
  - Outputs: product=16'h0000, busy=0, done=0.
  - Reset has priority over every other event, including start on the same edge.
- States: IDLE, CALC, DONE.
- IDLE:
  - On an edge with start=1: capture a_reg<=dataa, b_reg<=datab, acc<=0, cnt<=0, go to CALC.
  - Otherwise remain in IDLE.
- CALC (exactly 4 cycles, cnt 0..3): mult4x4 inputs and the shift applied to its product are:
  - cnt=0: a_reg[3:0] x b_reg[3:0], shift 0.
  - cnt=1: a_reg[7:4] x b_reg[3:0], shift 4.
  - cnt=2: a_reg[3:0] x b_reg[7:4], shift 4.
  - cnt=3: a_reg[7:4] x b_reg[7:4], shift 8.
- Accumulation arithmetic:
  - Each CALC edge does acc <= acc + ({8'h00, pp} << shift), computed in 16 bits.
  - The final sum never exceeds 16'hFE01, so no overflow handling is needed.
- CALC exit: on the cnt=3 edge, product <= acc + (pp<<8) and go to DONE; cnt wraps to 0.
- DONE (one cycle):
  - done=1, busy=0; next edge goes to IDLE.
  - A start asserted during DONE is ignored. The earliest new accept is the edge leaving the first IDLE cycle after DONE.
- busy is 1 in CALC only. done is 1 in DONE only. Both are decoded from registered state, so they are glitch-free.
- Latency:
  - Start accepted at edge k.
  - done is high during the cycle after edge k+4.
  - product is updated at edge k+4.
- start asserted while busy (CALC) is ignored. No error flag; operands are not re-captured.
- dataa/datab changes after acceptance have no effect on the running operation.
- product is not disturbed during CALC: the previous result stays visible until the new one is written.
- Reset mid-operation:
  - Abort on that edge, return to IDLE, clear product.
  - No done pulse is produced.
- start held continuously high: one operation every 6 cycles (accept edge, 4 CALC, DONE, then re-accept from IDLE).

Decomposition:
- Shared package (mult_pkg): state encoding constants (IDLE, CALC, DONE) and width constants (NIB_W=4, OP_W=8, RES_W=16).
- One sub-module: mult4x4, instantiated once.
  - Port map: .dataa(nibble of a_reg), .datab(nibble of b_reg), .product(pp).
  - No other sub-modules. Nibble muxes, shifter, adder and FSM stay inline.

Test Plan:
1. Reset, then start with dataa=8'hFF, datab=8'hFF for one cycle -> busy high for 4 cycles, then done pulses once with product=16'hFE01.
2. dataa=8'h12, datab=8'h34 -> product=16'h03A8 at done. Change dataa/datab every cycle during CALC -> result unchanged.
3. dataa=8'h00, datab=8'hA5 -> product=16'h0000. A previous result (e.g. 16'h03A8) remains on product until the done edge of this operation.
4. Assert start again at the second CALC cycle of dataa=8'h0F, datab=8'h10 -> ignored; single done; product=16'h00F0; no second busy period begins until start is sampled in IDLE.
5. Assert reset at the third CALC cycle of 8'hC8 x 8'h03 -> next cycle busy=0, done=0, product=16'h0000, and no done pulse follows. A subsequent 8'hC8 x 8'h03 -> product=16'h0258.
6. start held high across 3 back-to-back operands (8'h02x8'h03, 8'h10x8'h10, 8'h80x8'h02) -> done pulses exactly 6 cycles apart with products 16'h0006, 16'h0100, 16'h0100. Also assert start and reset on the same edge -> state remains IDLE.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared state encoding, widths and shift schedule for the sequential 8x8 multiplier.
package mult_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned OP_W  = 8;
  localparam int unsigned PP_W  = 2 * NIB_W;
  localparam int unsigned RES_W = 16;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned SH_W  = 4;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Weight of the partial product selected by step: LL=0, HL/LH=4, HH=8.
  function automatic logic [SH_W-1:0] step_shift(input logic [CNT_W-1:0] cnt);
    logic [SH_W-1:0] sh;
    case (cnt)
      2'd0:    sh = SH_W'(0);
      2'd3:    sh = SH_W'(8);
      default: sh = SH_W'(4);
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mult4x4.sv
// Combinational 4x4 unsigned multiplier core.
module mult4x4
  import mult_pkg::*;
(
  input  logic [NIB_W-1:0] dataa,
  input  logic [NIB_W-1:0] datab,
  output logic [PP_W-1:0]  product
);

  assign product = PP_W'(dataa) * PP_W'(datab);

endmodule

// File: rtl/mult8x8_seq.sv
// Sequential 8x8 unsigned multiplier: one nibble pair per cycle through a
// single mult4x4, shifted and accumulated over four CALC cycles.
module mult8x8_seq
  import mult_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  dataa,
  input  logic [OP_W-1:0]  datab,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] product
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OP_W-1:0]      a_q, a_d;
  logic [OP_W-1:0]      b_q, b_d;
  logic [RES_W-1:0]     acc_q, acc_d;
  logic [RES_W-1:0]     product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [NIB_W-1:0]     a_nib;
  logic [NIB_W-1:0]     b_nib;
  logic [PP_W-1:0]      pp;
  logic [RES_W-1:0]     pp_sh;
  logic [RES_W-1:0]     acc_sum;

  // cnt bit 0 picks the a nibble, bit 1 picks the b nibble.
  assign a_nib = cnt_q[0] ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0];
  assign b_nib = cnt_q[1] ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0];

  mult4x4 u_mult4x4 (
    .dataa   (a_nib),
    .datab   (b_nib),
    .product (pp)
  );

  assign pp_sh   = RES_W'(pp) << step_shift(cnt_q);
  assign acc_sum = acc_q + pp_sh;

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = dataa;
          b_d     = datab;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          product_d = acc_sum;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CALC);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mult8x8_seq.sv
// Scoreboard bench for mult8x8_seq: a transaction-level model predicts accepts,
// and a negedge monitor checks busy/done/product every cycle.
module tb_mult8x8_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic        busy;
  logic        done;
  logic [15:0] product;

  typedef struct {
    logic [15:0] exp;
    int          k;
  } op_t;

  op_t         sb[$];
  int          done_cyc[$];
  int          cyc;
  int          next_free;
  logic [15:0] prod_model;
  int          checks;
  int          errors;

  mult8x8_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dataa   (dataa),
    .datab   (datab),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: an accept is any non-reset edge with start high once the
  // previous operation's 6-cycle slot has elapsed.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      sb.delete();
      prod_model = 16'h0000;
      next_free  = cyc + 1;
    end else if (start && cyc >= next_free) begin
      sb.push_back('{exp: 16'(dataa) * 16'(datab), k: cyc});
      next_free = cyc + 6;
    end
  end

  // Monitor: busy during the four cycles after accept, done one cycle later.
  always @(negedge clk) begin
    logic be;
    logic de;
    if (cyc >= 1) begin
      be = 1'b0;
      de = 1'b0;
      if (sb.size() > 0) begin
        be = (cyc >= sb[0].k) && (cyc <= sb[0].k + 3);
        de = (cyc == sb[0].k + 4);
      end
      if (de) prod_model = sb[0].exp;
      chk("busy", 16'(busy), 16'(be));
      chk("done", 16'(done), 16'(de));
      chk("product", product, prod_model);
      if (de) begin
        done_cyc.push_back(cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation with optional start/reset injection i cycles after the accept edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit scramble,
                        input int inj_start, input int inj_reset);
    start = 1'b1;
    dataa = a;
    datab = b;
    for (int i = 0; i < 5; i++) begin
      tick();
      start = (i == inj_start);
      reset = (i == inj_reset);
      if (scramble || i == inj_start) begin
        dataa = 8'($urandom);
        datab = 8'($urandom);
      end
    end
    start = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int n0;
    int wd;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    next_free  = 0;
    prod_model = 16'h0000;
    reset      = 1'b1;
    start      = 1'b0;
    dataa      = 8'h00;
    datab      = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_product", product, 16'h0000);
    chk("reset_busy", 16'(busy), 16'h0000);
    tick();

    run_op(8'hFF, 8'hFF, 1'b0, -1, -1);
    chk("ff_x_ff", product, 16'hFE01);
    run_op(8'h12, 8'h34, 1'b1, -1, -1);
    chk("12_x_34_scrambled", product, 16'h03A8);
    run_op(8'h00, 8'hA5, 1'b0, -1, -1);
    chk("00_x_a5", product, 16'h0000);
    run_op(8'h0F, 8'h10, 1'b0, 1, -1);
    chk("0f_x_10_start_in_calc", product, 16'h00F0);
    tick();
    run_op(8'hC8, 8'h03, 1'b0, -1, 2);
    chk("abort_product", product, 16'h0000);
    run_op(8'hC8, 8'h03, 1'b0, -1, -1);
    chk("c8_x_03", product, 16'h0258);

    // start held high across three back-to-back operations.
    n0    = done_cyc.size();
    start = 1'b1;
    dataa = 8'h02;
    datab = 8'h03;
    tick();
    dataa = 8'h10;
    datab = 8'h10;
    repeat (6) tick();
    dataa = 8'h80;
    datab = 8'h02;
    repeat (6) tick();
    start = 1'b0;
    repeat (6) tick();
    chk("held_done_count", 16'(done_cyc.size() - n0), 16'd3);
    if (done_cyc.size() == n0 + 3) begin
      chk("held_gap1", 16'(done_cyc[n0+1] - done_cyc[n0]), 16'd6);
      chk("held_gap2", 16'(done_cyc[n0+2] - done_cyc[n0+1]), 16'd6);
    end
    chk("80_x_02", product, 16'h0100);

    // start and reset on the same edge.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("start_with_reset_busy", 16'(busy), 16'h0000);
    tick();

    for (int t = 0; t < 40; t++) begin
      int inj;
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_op(8'($urandom), 8'($urandom), 1'($urandom), inj, -1);
      repeat ($urandom_range(0, 3)) tick();
    end

    wd = 0;
    while (sb.size() > 0 && wd < 100) begin
      tick();
      wd++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d ops left, expected 0", sb.size());
    end
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
